// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch stage. Owns the fetch PC, presents it to the
//   instruction memory, captures the combinationally returned word and
//   buffers {pc, instr} pairs in a DEPTH-entry FIFO for the decode stage.
//   A redirect flushes every buffered entry and restarts fetch at a new,
//   word-aligned address.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   imem_addr    fetch address to instruction memory (the fetch PC)
//   imem_instr   instruction word for imem_addr, valid in the same cycle
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] ignored
//   deq_ready    decode accepts the head entry this cycle
//   deq_valid    head entry is valid (masked low during a redirect)
//   deq_instr    instruction word of the head entry
//   deq_pc       PC of the head entry
//   count        number of occupied entries
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_instr,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_instr,
  output logic [31:0]                deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      fpc;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [31:0]      instrStore [DEPTH];
  logic [31:0]      pcStore    [DEPTH];
  logic             deqFire;
  logic             enqFire;
  logic             unusedPcBits;

  // Redirect targets are forced to word alignment; the low bits are dropped.
  assign unusedPcBits = ^redirect_pc[1:0];

  assign imem_addr = fpc;
  assign deq_valid = (count != '0) && !redirect;
  assign deq_instr = instrStore[rdPtr];
  assign deq_pc    = pcStore[rdPtr];
  assign deqFire   = deq_valid && deq_ready;
  // A full queue can still accept a word when the head leaves on the same edge.
  assign enqFire   = !redirect && ((count < FULL_CNT) || deqFire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc   <= RESET_PC;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (redirect) begin
      fpc   <= {redirect_pc[31:2], 2'b00};
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (enqFire) begin
        wrPtr <= wrPtr + PTR_W'(1);
        fpc   <= fpc + 32'd4;
      end
      if (deqFire) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({enqFire, deqFire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instrStore[i] <= '0;
        pcStore[i]    <= '0;
      end
    end else if (enqFire) begin
      instrStore[wrPtr] <= imem_instr;
      pcStore[wrPtr]    <= fpc;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage between the instruction memory and the pipelined core's decode input.
- Owns the fetch PC, drives the imem address and captures the returned instruction words.
- Buffers fetched words with their PCs in a small FIFO and delivers them to decode over a valid/ready handshake.
- Supports a single-cycle redirect (branch/flush) that discards all buffered entries and restarts fetch at a new address.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset; word aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; low forces reset state immediately.
- imem_addr  output  32  fetch address to instruction memory; equals the internal fetch PC (fpc).
- imem_instr  input  32  instruction word; combinational imem read of imem_addr, valid in the same cycle.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 00.
- deq_ready  input  1  decode accepts the head entry this cycle.
- deq_valid  output  1  head entry is valid.
- deq_instr  output  32  instruction word of the head entry.
- deq_pc  output  32  PC of the head entry.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rst low, asynchronous):
  - fpc = RESET_PC; count = 0; read and write pointers = 0.
  - All entry storage = 0; deq_valid = 0; deq_instr = 0; deq_pc = 0; imem_addr = RESET_PC.
- Dequeue (deq):
  - deq = deq_valid && deq_ready.
  - deq_valid = (count != 0) && !redirect, combinational.
  - deq_instr and deq_pc show the entry at the read pointer whenever count != 0. Their values are don't-care when count == 0, except after reset, when they read 0.
- Enqueue (enq):
  - enq = !redirect && ((count < DEPTH) || deq).
  - On enq, the entry at the write pointer captures {fpc, imem_instr}, the write pointer advances, and fpc <= fpc + 4.
  - When full and no deq: no enqueue, fpc holds, and imem_addr stays stable.
- Count update:
  - enq && !deq: +1.
  - deq && !enq: −1.
  - both or neither: unchanged.
- Full with simultaneous dequeue: the head is released and the new word is written in the same edge; count stays DEPTH.
- Latency:
  - A word fetched at edge N is visible on deq_* in the cycle after edge N.
  - After reset release, deq_valid rises one cycle after the first clk edge.
  - Empty-queue throughput is one instruction per cycle.
- Redirect has priority over everything:
  - On an edge with redirect = 1: count <= 0, both pointers <= 0, fpc <= {redirect_pc[31:2], 2'b00}.
  - No enqueue occurs that cycle.
  - deq_valid is masked low, so no handshake completes even if deq_ready = 1.
  - The next cycle fetches from the new address; its word is visible one cycle after that.
- Back-to-back redirects: each redirect flushes again, and only the last redirect_pc takes effect.
- Wrap-around:
  - fpc increments modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.
  - Read and write pointers wrap modulo DEPTH.
- deq_ready while empty has no effect; count never underflows or overflows.
- Reset asserted mid-operation discards all entries immediately. Behaviour after release is identical to power-on.
- imem_instr is sampled only on edges where enq = 1.

Test Plan:
- Reset then release, deq_ready = 1, imem returning 32'hE000_0000|addr:
  - Cycle after first edge: deq_valid = 1, deq_pc = 0x0.
  - Then deq_pc = 0x4, 0x8, … on consecutive cycles; count stays 1.
- Fill with deq_ready = 0:
  - After 4 edges: count = 4 and imem_addr = 0x10, both holding for further cycles.
  - Head remains deq_pc = 0x0.
- Full plus dequeue:
  - count = 4, then deq_ready = 1 for one cycle.
  - Next cycle: count = 4, head deq_pc = 0x4, newest entry PC 0x10, imem_addr = 0x14.
- Redirect with 3 entries, deq_ready = 1, redirect_pc = 0x103:
  - deq_valid = 0 during the redirect cycle.
  - Next cycle: count = 0 and imem_addr = 0x100.
  - Following cycle: deq_valid = 1, deq_pc = 0x100.
- Wrap: RESET_PC = 32'hFFFF_FFF8, deq_ready = 1; dequeued PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset mid-stream:
  - Assert rst low between edges with count = 2.
  - Immediately: deq_valid = 0, count = 0, imem_addr = RESET_PC, without waiting for a clk edge.
